// File: rtl/pio_in_pkg.sv
// Shared constants for the debounced input PIO: register addresses and
// edge-capture mode encodings.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  // True when a debounced change in direction 'rise' counts as an event for 'mode'.
  function automatic logic edge_selected(input int mode, input logic rise);
    logic sel;
    sel = 1'b0;
    if (mode == int'(EDGE_ANY)) begin
      sel = 1'b1;
    end else if (mode == int'(EDGE_RISE)) begin
      sel = rise;
    end else if (mode == int'(EDGE_FALL)) begin
      sel = ~rise;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, stability counter and debounced flop,
// with a pulse (and its direction) on the edge where debounced changes.
module pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic synced,
  output logic debounced,
  output logic change,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  // change is asserted in the cycle before debounced flips, so debounced takes synced
  assign rise   = synced;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign change = synced ^ debounced;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          debounced <= 1'b0;
        end else begin
          debounced <= synced;
        end
      end
    end else begin : g_count
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt;

      // Fires on the DEBOUNCE_CYCLES-th consecutive edge that synced differs.
      assign change = (synced != debounced) && (cnt == CNT_LAST);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt       <= '0;
          debounced <= 1'b0;
        end else if (synced == debounced) begin
          cnt <= '0;
        end else if (change) begin
          cnt       <= '0;
          debounced <= synced;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pio_in_debounce_irq.sv
// Avalon-MM input PIO: per-bit debounce, edge capture with W1C clear,
// maskable level interrupt and a registered read mux.
module pio_in_debounce_irq
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  logic [WIDTH-1:0] synced_vec;
  logic [WIDTH-1:0] debounced_vec;
  logic [WIDTH-1:0] change_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] event_vec;
  logic [WIDTH-1:0] clear_vec;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin      (in_port[i]),
      .synced   (synced_vec[i]),
      .debounced(debounced_vec[i]),
      .change   (change_vec[i]),
      .rise     (rise_vec[i])
    );
  end

  assign wr_en = chipselect & write;

  always_comb begin
    event_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      event_vec[i] = change_vec[i] & edge_selected(EDGE_MODE, rise_vec[i]);
    end
  end

  always_comb begin
    clear_vec = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      clear_vec = writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_en && (address == ADDR_MASK)) begin
      irq_mask <= writedata;
    end
  end

  // A new event outranks a same-edge clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_vec) | event_vec;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = debounced_vec;
      ADDR_RAW:  rd_mux = synced_vec;
      ADDR_MASK: rd_mux = irq_mask;
      ADDR_EDGE: rd_mux = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Directed bench for pio_in_debounce_irq: a register-access vector table plus
// hand-timed sequences for debounce, W1C, edge modes and mid-count reset.
module tb_pio_in_debounce_irq;

  localparam int W = 18;

  logic         clk;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write;
  logic [W-1:0] writedata;
  logic [W-1:0] in_port;
  logic [W-1:0] rd;
  logic [W-1:0] rd_r;
  logic [W-1:0] rd_f;
  logic         irq;
  logic         irq_r;
  logic         irq_f;

  int checks;
  int errors;

  typedef struct {
    logic         cs;
    logic         wr;
    logic [1:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp_rd;
    logic         exp_irq;
  } vec_t;

  vec_t vecs[13];

  pio_in_debounce_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port), .readdata(rd), .irq(irq)
  );

  pio_in_debounce_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port), .readdata(rd_r), .irq(irq_r)
  );

  pio_in_debounce_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port), .readdata(rd_f), .irq(irq_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%05h expected=0x%05h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    chipselect = v.cs;
    write      = v.wr;
    address    = v.addr;
    writedata  = v.wdata;
    tick();
    write      = 1'b0;
    chipselect = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write      = 1'b0;
    tick();
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [W-1:0] d);
    address    = a;
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = d;
    tick();
    write      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic leak;
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    in_port    = '0;

    //                cs    wr    addr  wdata     exp_rd    exp_irq
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 18'h00000, 18'h00000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 18'h00000, 18'h00000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 18'h00000, 18'h00000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 18'h00000, 18'h00000, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 18'h2AAAA, 18'h00000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 18'h00000, 18'h2AAAA, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 18'h3FFFF, 18'h00000, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 18'h3FFFF, 18'h00000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 18'h00000, 18'h00000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 18'h3FFFF, 18'h00000, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 18'h00000, 18'h2AAAA, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 18'h15555, 18'h00000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 18'h00000, 18'h00000, 1'b0};

    $display("[TB] reset and register access table");
    ticks(3);
    checkOutput("reset_readdata", 32'(rd), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_readdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      checkOutput($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    $display("[TB] clean step on bit 0");
    readReg(2'd0);
    in_port[0] = 1'b1;
    ticks(6);
    checkOutput("step_before", 32'(rd), 32'h00000);
    tick();
    checkOutput("step_after", 32'(rd), 32'h00001);
    readReg(2'd3);
    checkOutput("step_edge", 32'(rd), 32'h00001);
    checkOutput("step_irq_masked", 32'(irq), 32'h0);
    writeReg(2'd2, 18'h00001);
    checkOutput("step_irq_unmasked", 32'(irq), 32'h1);

    $display("[TB] bounce on bit 3");
    writeReg(2'd3, 18'h3FFFF);
    checkOutput("bounce_clear_irq", 32'(irq), 32'h0);
    readReg(2'd0);
    leak = 1'b0;
    for (int p = 0; p < 5; p++) begin
      in_port[3] = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); if (rd !== 18'h00001) leak = 1'b1; end
      in_port[3] = 1'b0;
      for (int k = 0; k < 3; k++) begin tick(); if (rd !== 18'h00001) leak = 1'b1; end
    end
    checkOutput("bounce_no_leak", 32'(leak), 32'h0);
    in_port[3] = 1'b1;
    ticks(6);
    checkOutput("bounce_before", 32'(rd), 32'h00001);
    tick();
    checkOutput("bounce_after", 32'(rd), 32'h00009);
    readReg(2'd3);
    checkOutput("bounce_edge", 32'(rd), 32'h00008);
    checkOutput("bounce_irq", 32'(irq), 32'h0);

    $display("[TB] write-1-to-clear");
    writeReg(2'd3, 18'h3FFFF);
    in_port = 18'h0000C;
    ticks(8);
    readReg(2'd3);
    checkOutput("w1c_edge_before", 32'(rd), 32'h00005);
    checkOutput("w1c_irq_before", 32'(irq), 32'h1);
    writeReg(2'd3, 18'h00001);
    checkOutput("w1c_irq_after", 32'(irq), 32'h0);
    readReg(2'd3);
    checkOutput("w1c_edge_after", 32'(rd), 32'h00004);
    writeReg(2'd2, 18'h00004);
    checkOutput("w1c_irq_mask4", 32'(irq), 32'h1);
    writeReg(2'd3, 18'h00004);
    checkOutput("w1c_irq_cleared", 32'(irq), 32'h0);
    in_port = 18'h00008;
    ticks(5);
    writeReg(2'd3, 18'h00004);
    checkOutput("w1c_set_wins_irq", 32'(irq), 32'h1);
    readReg(2'd3);
    checkOutput("w1c_set_wins_edge", 32'(rd), 32'h00004);
    readReg(2'd0);
    checkOutput("w1c_data", 32'(rd), 32'h00008);

    $display("[TB] edge mode selection on bit 1");
    writeReg(2'd2, 18'h3FFFF);
    writeReg(2'd3, 18'h3FFFF);
    in_port = 18'h0000A;
    ticks(8);
    readReg(2'd0);
    checkOutput("rise_data_fallmode", 32'(rd_f), 32'h0000A);
    readReg(2'd3);
    checkOutput("rise_edge_risemode", 32'(rd_r), 32'h00002);
    checkOutput("rise_edge_fallmode", 32'(rd_f), 32'h00000);
    checkOutput("rise_irq_risemode", 32'(irq_r), 32'h1);
    checkOutput("rise_irq_fallmode", 32'(irq_f), 32'h0);
    writeReg(2'd3, 18'h3FFFF);
    in_port = 18'h00008;
    ticks(8);
    readReg(2'd0);
    checkOutput("fall_data_risemode", 32'(rd_r), 32'h00008);
    readReg(2'd3);
    checkOutput("fall_edge_risemode", 32'(rd_r), 32'h00000);
    checkOutput("fall_edge_fallmode", 32'(rd_f), 32'h00002);
    checkOutput("fall_edge_anymode", 32'(rd), 32'h00002);
    checkOutput("fall_irq_risemode", 32'(irq_r), 32'h0);
    checkOutput("fall_irq_fallmode", 32'(irq_f), 32'h1);

    $display("[TB] reset mid-debounce");
    checkOutput("midreset_irq_before", 32'(irq), 32'h1);
    in_port = 18'h00028;
    ticks(4);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_readdata", 32'(rd), 32'h0);
    checkOutput("midreset_irq", 32'(irq), 32'h0);
    in_port = '0;
    ticks(2);
    reset_n = 1'b1;
    ticks(10);
    checkOutput("postreset_irq", 32'(irq), 32'h0);
    readReg(2'd3);
    checkOutput("postreset_edge", 32'(rd), 32'h00000);
    readReg(2'd0);
    checkOutput("postreset_data", 32'(rd), 32'h00000);
    readReg(2'd2);
    checkOutput("postreset_mask", 32'(rd), 32'h00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
